// File: rtl/gtype.sv
// rtl/gtype.sv - shared types for the 10GBASE-R receive block-sync path
package gtype;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } blk66_t;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST_SH,
    SLIP,
    SLIP_WAIT
  } lock_state_t;

  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/g10_rx_gearbox_32to66.sv
// rtl/g10_rx_gearbox_32to66.sv - 32-to-66 bit receive gearbox with single-bit slip
module g10_rx_gearbox_32to66
  import gtype::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [31:0] rx_data,
  input  logic        slip_req,
  output blk66_t      blk,
  output logic        blk_valid,
  output logic        hdr_err,
  output logic [6:0]  cnt
);

  // Bits are held LSB-first; everything above cnt is kept zero so new words can be OR-ed in.
  logic [97:0] sr_q;
  logic [97:0] sr_app;
  logic [97:0] sr_slp;
  logic [97:0] sr_nxt;
  logic [6:0]  cnt_app;
  logic [6:0]  cnt_slp;
  logic [6:0]  cnt_nxt;
  logic        emit;

  always_comb begin
    sr_app  = sr_q | ({66'd0, rx_data} << cnt);
    cnt_app = cnt + 7'd32;
    sr_slp  = slip_req ? (sr_app >> 1) : sr_app;
    cnt_slp = slip_req ? (cnt_app - 7'd1) : cnt_app;
    emit    = (cnt_slp >= 7'd66);
    sr_nxt  = emit ? (sr_slp >> 66) : sr_slp;
    cnt_nxt = emit ? (cnt_slp - 7'd66) : cnt_slp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      cnt       <= '0;
      blk       <= '0;
      blk_valid <= 1'b0;
      hdr_err   <= 1'b0;
    end else if (!rx_rdy) begin
      sr_q      <= '0;
      cnt       <= '0;
      blk       <= '0;
      blk_valid <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      sr_q      <= sr_nxt;
      cnt       <= cnt_nxt;
      blk_valid <= emit;
      hdr_err   <= emit && !sh_valid(sr_slp[1:0]);
      if (emit) begin
        blk.hdr  <= sr_slp[1:0];
        blk.data <= sr_slp[65:2];
      end
    end
  end

endmodule

// File: rtl/g10_rx_block_sync.sv
// rtl/g10_rx_block_sync.sv - 10GBASE-R receive gearbox plus block-lock state machine
module g10_rx_block_sync
  import gtype::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT_BLK  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pma_rx,
  input  logic        pma_rx_rdy,
  output logic [63:0] blk_data,
  output logic [1:0]  blk_hdr,
  output logic        blk_valid,
  output logic        block_lock,
  output logic        sh_err,
  output logic        slip
);

  localparam logic [6:0] SH_CNT_LAST = 7'(SH_CNT_MAX);
  localparam logic [4:0] INV_LAST    = 5'(SH_INVALID_MAX);
  localparam logic [3:0] WAIT_LAST   = 4'(SLIP_WAIT_BLK - 1);

  blk66_t      blk;
  logic [6:0]  gb_cnt;
  lock_state_t state;
  logic [6:0]  sh_cnt;
  logic [4:0]  inv_cnt;
  logic [3:0]  wait_cnt;
  logic        hdr_ok;
  logic [6:0]  sh_cnt_inc;
  logic [4:0]  inv_cnt_inc;
  logic [4:0]  inv_cnt_nxt;

  // The registered slip strobe doubles as the gearbox request, so the shift lands one cycle later.
  g10_rx_gearbox_32to66 u_gearbox (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (pma_rx_rdy),
    .rx_data   (pma_rx),
    .slip_req  (slip),
    .blk       (blk),
    .blk_valid (blk_valid),
    .hdr_err   (sh_err),
    .cnt       (gb_cnt)
  );

  assign blk_data = blk.data;
  assign blk_hdr  = blk.hdr;

  always_comb begin
    hdr_ok      = sh_valid(blk.hdr);
    sh_cnt_inc  = (sh_cnt == 7'h7f) ? sh_cnt : sh_cnt + 7'd1;
    inv_cnt_inc = (inv_cnt == 5'h1f) ? inv_cnt : inv_cnt + 5'd1;
    inv_cnt_nxt = hdr_ok ? inv_cnt : inv_cnt_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCK_INIT;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      wait_cnt   <= '0;
    end else if (!pma_rx_rdy) begin
      state      <= LOCK_INIT;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      wait_cnt   <= '0;
    end else begin
      slip <= 1'b0;
      case (state)
        LOCK_INIT: begin
          block_lock <= 1'b0;
          sh_cnt     <= '0;
          inv_cnt    <= '0;
          state      <= TEST_SH;
        end
        TEST_SH: begin
          if (blk_valid) begin
            // A bad header that forces a slip wins over a window that completes on the same block.
            if (!hdr_ok && (!block_lock || inv_cnt_inc >= INV_LAST)) begin
              state      <= SLIP;
              block_lock <= 1'b0;
              slip       <= 1'b1;
              sh_cnt     <= '0;
              inv_cnt    <= '0;
              wait_cnt   <= '0;
            end else if (sh_cnt_inc >= SH_CNT_LAST) begin
              sh_cnt  <= '0;
              inv_cnt <= '0;
              if (inv_cnt_nxt == 5'd0) block_lock <= 1'b1;
            end else begin
              sh_cnt  <= sh_cnt_inc;
              inv_cnt <= inv_cnt_nxt;
            end
          end
        end
        SLIP: begin
          state <= SLIP_WAIT;
        end
        SLIP_WAIT: begin
          if (blk_valid) begin
            if (wait_cnt == WAIT_LAST) state <= TEST_SH;
            else wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= LOCK_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_g10_rx_block_sync.sv
// tb/tb_g10_rx_block_sync.sv - directed bench for the 10GBASE-R receive block sync
module tb_g10_rx_block_sync;

  logic        clk;
  logic        rst_n;
  logic [31:0] pma_rx;
  logic        pma_rx_rdy;
  logic [63:0] blk_data;
  logic [1:0]  blk_hdr;
  logic        blk_valid;
  logic        block_lock;
  logic        sh_err;
  logic        slip;

  g10_rx_block_sync dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pma_rx     (pma_rx),
    .pma_rx_rdy (pma_rx_rdy),
    .blk_data   (blk_data),
    .blk_hdr    (blk_hdr),
    .blk_valid  (blk_valid),
    .block_lock (block_lock),
    .sh_err     (sh_err),
    .slip       (slip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [1:0]  src_hdr[$];
  logic [63:0] src_data[$];
  bit          bitq[$];
  logic [1:0]  rx_hdr[$];
  logic [63:0] rx_data[$];

  int cyc;
  int blk64_cyc;
  int lock_rise_cyc;
  bit lock_seen;
  bit lock_q;
  int slip_cnt;
  int sherr_cnt;
  int bad_lo, bad_hi, bad_lo2, bad_hi2;
  int k, n0, j;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mix32(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> 16);
    y = y * 32'h7feb352d;
    y = y ^ (y >> 15);
    y = y * 32'h846ca68b;
    y = y ^ (y >> 16);
    return y;
  endfunction

  // Source blocks: alternating 01/10 headers, hashed payload, optional 00 headers in two index ranges.
  task automatic gen_block();
    int          idx;
    logic [1:0]  h;
    logic [63:0] d;
    idx = src_hdr.size();
    h = (idx % 2 == 0) ? 2'b01 : 2'b10;
    if ((idx >= bad_lo && idx <= bad_hi) || (idx >= bad_lo2 && idx <= bad_hi2)) h = 2'b00;
    d = {mix32(32'(idx * 2 + 1)), mix32(32'(idx * 2))};
    src_hdr.push_back(h);
    src_data.push_back(d);
    for (int b = 0; b < 2; b++) bitq.push_back(h[b]);
    for (int b = 0; b < 64; b++) bitq.push_back(d[b]);
  endtask

  task automatic pop32(output logic [31:0] w);
    while (bitq.size() < 32) gen_block();
    for (int b = 0; b < 32; b++) w[b] = bitq.pop_front();
  endtask

  task automatic src_reset();
    src_hdr.delete();
    src_data.delete();
    bitq.delete();
    rx_hdr.delete();
    rx_data.delete();
    slip_cnt      = 0;
    sherr_cnt     = 0;
    blk64_cyc     = -1000;
    lock_rise_cyc = -2000;
    lock_seen     = 1'b0;
    lock_q        = block_lock;
    bad_lo  = -1; bad_hi  = -2;
    bad_lo2 = -1; bad_hi2 = -2;
  endtask

  task automatic step();
    logic [31:0] w;
    if (pma_rx_rdy) begin
      pop32(w);
      pma_rx = w;
    end else begin
      pma_rx = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (block_lock && !lock_q) begin
      lock_rise_cyc = cyc;
      lock_seen     = 1'b1;
    end
    lock_q = block_lock;
    if (blk_valid) begin
      rx_hdr.push_back(blk_hdr);
      rx_data.push_back(blk_data);
      if (rx_hdr.size() == 64) blk64_cyc = cyc;
    end
    if (slip) slip_cnt++;
    if (sh_err) sherr_cnt++;
  endtask

  task automatic run_blocks(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (rx_hdr.size() < n && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, 66'(rx_hdr.size() >= n), 66'd1);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pma_rx_rdy = 1'b0;
    pma_rx     = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n      = 1'b1;
    pma_rx_rdy = 1'b1;
    src_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n      = 1'b1;
    pma_rx_rdy = 1'b0;
    pma_rx     = '0;
    src_reset();
    #1;

    // Aligned stream: throughput, wrap, lock latency, payload; then bad-header windows.
    do_reset();
    check_eq("reset_data", 66'(blk_data), 66'd0);
    check_eq("reset_ctrl", 66'({blk_hdr, blk_valid, block_lock, sh_err, slip}), 66'd0);
    release_reset();
    bad_lo = 130; bad_hi = 144; bad_lo2 = 200; bad_hi2 = 215;
    repeat (33) step();
    check_eq("t1_blocks_33clk", 66'(rx_hdr.size()), 66'd16);
    check_eq("t1_cnt_wrap", 66'(dut.u_gearbox.cnt), 66'd0);
    repeat (33) step();
    check_eq("t1_blocks_66clk", 66'(rx_hdr.size()), 66'd32);
    run_blocks("t1_reach_70", 70, 200);
    check_eq("t1_lock_latency", 66'(lock_rise_cyc - blk64_cyc), 66'd1);
    check_eq("t1_locked", 66'(block_lock), 66'd1);
    check_eq("t1_no_slip", 66'(slip_cnt), 66'd0);
    check_eq("t1_no_sherr", 66'(sherr_cnt), 66'd0);
    for (int i = 0; i < 70; i++)
      if (i < rx_hdr.size())
        check_eq($sformatf("t1_payload_%0d", i), {rx_hdr[i], rx_data[i]}, {src_hdr[i], src_data[i]});

    run_blocks("t3_reach_200", 200, 400);
    check_eq("t3_lock_held", 66'(block_lock), 66'd1);
    check_eq("t3_sherr_15", 66'(sherr_cnt), 66'd15);
    check_eq("t3_no_slip", 66'(slip_cnt), 66'd0);
    run_blocks("t3_reach_216", 216, 100);
    check_eq("t3_lock_at_16th", 66'(block_lock), 66'd1);
    check_eq("t3_sherr_31", 66'(sherr_cnt), 66'd31);
    step();
    check_eq("t3_lock_drop", 66'(block_lock), 66'd0);
    check_eq("t3_slip_pulse", 66'(slip), 66'd1);
    repeat (2) step();
    check_eq("t3_one_slip", 66'(slip_cnt), 66'd1);

    // Receiver-ready drop while locked, then relock on a freshly aligned stream.
    do_reset();
    release_reset();
    run_blocks("t4_reach_70", 70, 200);
    check_eq("t4_locked", 66'(block_lock), 66'd1);
    pma_rx_rdy = 1'b0;
    step();
    check_eq("t4_lock_cleared", 66'(block_lock), 66'd0);
    check_eq("t4_valid_cleared", 66'(blk_valid), 66'd0);
    check_eq("t4_cnt_cleared", 66'(dut.u_gearbox.cnt), 66'd0);
    src_reset();
    pma_rx_rdy = 1'b1;
    run_blocks("t4_reach_70b", 70, 200);
    check_eq("t4_relock_latency", 66'(lock_rise_cyc - blk64_cyc), 66'd1);
    check_eq("t4_relocked", 66'(block_lock), 66'd1);
    check_eq("t4_no_slip", 66'(slip_cnt), 66'd0);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t4_payload_%0d", i), {rx_hdr[i], rx_data[i]}, {src_hdr[i], src_data[i]});

    // Asynchronous reset between edges while a block is on the outputs.
    k = 0;
    while (!(blk_valid && blk_data != 64'd0) && k < 20) begin
      step();
      k++;
    end
    check_eq("t5_precond", 66'(blk_valid), 66'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_data", 66'(blk_data), 66'd0);
    check_eq("t5_async_ctrl", 66'({blk_hdr, blk_valid, block_lock, sh_err, slip}), 66'd0);
    check_eq("t5_async_cnt", 66'(dut.u_gearbox.cnt), 66'd0);
    @(posedge clk);
    #1;
    release_reset();
    step();
    check_eq("t5_clk1_valid", 66'(blk_valid), 66'd0);
    step();
    check_eq("t5_clk2_valid", 66'(blk_valid), 66'd0);
    step();
    check_eq("t5_clk3_valid", 66'(blk_valid), 66'd1);
    check_eq("t5_first_block", {blk_hdr, blk_data}, {src_hdr[0], src_data[0]});

    // Bad header on the 64th block of an unlocked window: slip beats lock.
    do_reset();
    release_reset();
    bad_lo = 63; bad_hi = 63;
    run_blocks("t6_reach_64", 64, 200);
    check_eq("t6_unlocked_at_64", 66'(block_lock), 66'd0);
    check_eq("t6_sherr", 66'(sherr_cnt), 66'd1);
    step();
    check_eq("t6_slip_taken", 66'(slip), 66'd1);
    check_eq("t6_no_lock", 66'(block_lock), 66'd0);
    repeat (20) step();
    check_eq("t6_never_locked", 66'(lock_seen), 66'd0);

    // Stream delayed by 17 bits: one slip per bit, then lock on aligned blocks.
    do_reset();
    release_reset();
    for (int b = 0; b < 17; b++) bitq.push_back(1'b0);
    k = 0;
    while (!block_lock && k < 3000) begin
      step();
      k++;
    end
    check_eq("t2_locked", 66'(block_lock), 66'd1);
    check_eq("t2_slip_count", 66'(slip_cnt), 66'd17);
    n0 = rx_hdr.size();
    run_blocks("t2_reach_more", n0 + 4, 40);
    j = -1;
    if (n0 < rx_data.size())
      for (int s = 0; s < src_data.size(); s++)
        if (j < 0 && src_data[s] == rx_data[n0]) j = s;
    check_eq("t2_found", 66'(j >= 0), 66'd1);
    if (j >= 0)
      for (int m = 0; m < 4; m++)
        if (j + m < src_data.size() && n0 + m < rx_data.size())
          check_eq($sformatf("t2_aligned_%0d", m), {rx_hdr[n0 + m], rx_data[n0 + m]},
                   {src_hdr[j + m], src_data[j + m]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/g10_rx_block_sync.md
Name: g10_rx_block_sync

Overview:
Receive-side 10GBASE-R stage placed directly downstream of the PMA wrapper's 32-bit parallel receive output (pma_rx / pma_rx_rdy / pma_rx_clk).
- Performs the 32→66 gearbox and the Clause 49 block-lock search, using an internal bit slip.
- Emits aligned 66-bit blocks (2-bit sync header plus 64-bit payload) with a block_lock flag, for the descrambler/decoder stage.
- Runs entirely in the PMA receive-clock domain.

Parameters:
SH_CNT_MAX, 64, blocks per sync-header test window
SH_INVALID_MAX, 16, invalid headers in one window that cause loss of lock
SLIP_WAIT_BLK, 2, blocks ignored by the lock FSM after each slip

Ports:
clk  input  1  PMA receive clock (pma_rx_clk)
rst_n  input  1  reset, asynchronous, active-low
pma_rx  input  32  raw PMA receive word; bit 0 is the first bit received on the line
pma_rx_rdy  input  1  PMA receiver ready; low = flush
blk_data  output  64  block payload = gearbox bits [65:2]
blk_hdr  output  2  sync header = gearbox bits [1:0]
blk_valid  output  1  one-cycle strobe, block present on blk_data/blk_hdr
block_lock  output  1  block lock achieved
sh_err  output  1  strobe coincident with blk_valid when blk_hdr is 00 or 11
slip  output  1  one-cycle strobe when a bit slip is applied (status only)

Behaviour:
Reset
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- While rst_n is low, all outputs are 0; gearbox count is 0, buffer is 0, FSM is in LOCK_INIT.
- pma_rx_rdy low has the same effect, applied synchronously on the next edge. The FSM stays in LOCK_INIT while pma_rx_rdy is low.

Gearbox
- Buffer is 98 bits; cnt is 0..97 valid bits, held LSB-first.
- Each cycle with pma_rx_rdy high, in this order:
  - Append: buf |= pma_rx << cnt; cnt += 32.
  - If the FSM's slip request is active this cycle: buf >>= 1; cnt -= 1.
  - If cnt ≥ 66: register buf[65:0] onto blk_hdr/blk_data, pulse blk_valid, then buf >>= 66 and cnt -= 66.
- Latency: a block appears 1 clk after the cycle that delivered its last bit.
- Throughput: with no slips, exactly 16 blocks per 33 cycles, and never two blocks in one cycle. The invariant cnt ≤ 65 holds after every cycle.
- Wrap-around: cnt cycles back to 0 after 33 slip-free cycles.

Lock FSM (advances only on blk_valid)
- LOCK_INIT: block_lock = 0; clear sh_cnt and inv_cnt; go to TEST_SH.
- TEST_SH: on each block, sh_cnt++. A header of 01 or 10 is valid; otherwise inv_cnt++ and sh_err is pulsed.
  - Unlocked, any invalid header → SLIP.
  - Locked, inv_cnt reaches SH_INVALID_MAX → SLIP.
  - sh_cnt reaches SH_CNT_MAX with inv_cnt = 0 → block_lock = 1; clear both counters.
  - sh_cnt reaches SH_CNT_MAX with 0 < inv_cnt < SH_INVALID_MAX while locked → clear both counters; lock is held.
- SLIP: block_lock = 0; clear counters; assert the slip request and the slip output for exactly one clk (applied on the next gearbox cycle); go to SLIP_WAIT.
- SLIP_WAIT: discard SLIP_WAIT_BLK blocks without counting them; go to TEST_SH.
- The invalid-header case takes priority over window completion when both occur on the same block.
- Counters are 7 bits (sh_cnt) and 5 bits (inv_cnt); they saturate and never wrap.

Decomposition:
- Shared package gtype gets:
  - SH_DATA = 2'b01, SH_CTRL = 2'b10
  - typedef blk66_t {hdr[1:0], data[63:0]}
  - FSM state enum
- Sub-module g10_rx_gearbox_32to66 holds the buffer, cnt and slip logic; the top module holds the lock FSM and counters.

Test Plan:
1. Aligned stream of blocks with alternating 01/10 headers, offset 0 → blk_valid pulses 16 times per 33 clk; block_lock rises 1 clk after the 64th block; payload matches the source bit-exactly.
2. Same stream pre-delayed by 17 bits → exactly 17 slip pulses; then block_lock after 64 valid blocks; data aligned.
3. Locked; inject 15 bad headers (00) in one 64-block window → block_lock stays 1 and sh_err pulses 15 times. Inject 16 bad headers → block_lock drops on the 16th, followed by one slip pulse.
4. Locked; drop pma_rx_rdy for 1 clk mid-stream → next edge: block_lock = 0, blk_valid = 0, cnt = 0. Relock after 64 valid blocks once the stream is realigned.
5. Assert rst_n low between clock edges mid-block → all outputs are 0 immediately, before the next edge. After release, the first blk_valid appears on the 3rd clk with data (cnt 0→32→64→96).
6. Invalid header on the 64th block of an unlocked window → SLIP is taken and no lock occurs (priority check).
